// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with one-shot/periodic terminal-count pulse.
// Ports: clk (falling-edge), reset (async low), enable, stop, load_valid/load_value/periodic
//   in; load_ready, busy, tc, count out.
module down_counter_timer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         stop,
  input  logic         load_valid,
  input  logic [N-1:0] load_value,
  input  logic         periodic,
  output logic         load_ready,
  output logic         busy,
  output logic         tc,
  output logic [N-1:0] count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       r_state;
  logic [N-1:0] r_count;
  logic [N-1:0] r_reload;
  logic         r_mode;
  logic         r_tc;

  state_t       w_state;
  logic [N-1:0] w_count;
  logic [N-1:0] w_reload;
  logic         w_mode;
  logic         w_tc;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_reload <= w_reload;
      r_mode   <= w_mode;
      r_tc     <= w_tc;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_count  = r_count;
    w_reload = r_reload;
    w_mode   = r_mode;
    w_tc     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load_valid) begin
          w_reload = load_value;
          w_count  = load_value;
          w_mode   = periodic;
          // A zero load expires on the spot and never enters RUN.
          if (load_value == '0) w_tc = 1'b1;
          else                  w_state = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state = S_IDLE;
        end else if (!enable) begin
          w_count = r_count;
        end else if (r_count == ONE) begin
          w_tc = 1'b1;
          if (r_mode) begin
            w_count = r_reload;
          end else begin
            w_count = '0;
            w_state = S_IDLE;
          end
        end else begin
          w_count = r_count - ONE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state == S_RUN);
  assign tc         = r_tc;
  assign count      = r_count;

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: scoreboard bench for down_counter_timer.
// Expectations queued per driven edge; checked on the opposite clock edge.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       stop;
  logic       load_valid;
  logic [7:0] load_value;
  logic       periodic;
  logic       load_ready;
  logic       busy;
  logic       tc;
  logic [7:0] count;

  typedef struct {
    string tag;
    int    cnt;
    int    tcv;
    int    bsy;
    int    rdy;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .stop       (stop),
    .load_valid (load_valid),
    .load_value (load_value),
    .periodic   (periodic),
    .load_ready (load_ready),
    .busy       (busy),
    .tc         (tc),
    .count      (count)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".count"}, int'(count), e.cnt);
      chk({e.tag, ".tc"}, int'(tc), e.tcv);
      chk({e.tag, ".busy"}, int'(busy), e.bsy);
      chk({e.tag, ".ready"}, int'(load_ready), e.rdy);
    end
  end

  // Expect these values after the next falling edge; return at posedge+1.
  task automatic tick(input string tag, input int c, input int t,
                      input int b, input int r);
    exp_t e;
    e.tag = tag;
    e.cnt = c;
    e.tcv = t;
    e.bsy = b;
    e.rdy = r;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v, input logic per);
    load_valid = 1'b1;
    load_value = 8'(v);
    periodic   = per;
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b1;
    stop       = 1'b0;
    load_valid = 1'b1;
    load_value = 8'd5;
    periodic   = 1'b0;
    @(posedge clk);
    #1;

    tick("rst0", 0, 0, 0, 1);
    tick("rst1", 0, 0, 0, 1);
    reset      = 1'b1;
    load_valid = 1'b0;
    tick("idle", 0, 0, 0, 1);

    load(4, 1'b0);
    tick("os_ld", 4, 0, 1, 0);
    load_valid = 1'b0;
    tick("os3", 3, 0, 1, 0);
    tick("os2", 2, 0, 1, 0);
    tick("os1", 1, 0, 1, 0);
    tick("os0", 0, 1, 0, 1);
    tick("os_end", 0, 0, 0, 1);

    load(3, 1'b1);
    tick("per_ld", 3, 0, 1, 0);
    load_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      int m;
      m = i % 3;
      if (m == 1)      tick("per", 2, 0, 1, 0);
      else if (m == 2) tick("per", 1, 0, 1, 0);
      else             tick("per_tc", 3, 1, 1, 0);
    end
    stop = 1'b1;
    tick("per_stop", 2, 0, 0, 1);
    stop = 1'b0;

    load(5, 1'b0);
    tick("gate_ld", 5, 0, 1, 0);
    load_valid = 1'b0;
    tick("gate4", 4, 0, 1, 0);
    tick("gate3", 3, 0, 1, 0);
    enable = 1'b0;
    tick("hold", 3, 0, 1, 0);
    tick("hold", 3, 0, 1, 0);
    tick("hold", 3, 0, 1, 0);
    enable = 1'b1;
    tick("gate2", 2, 0, 1, 0);
    tick("gate1", 1, 0, 1, 0);
    tick("gate_tc", 0, 1, 0, 1);
    tick("gate_end", 0, 0, 0, 1);

    load(2, 1'b0);
    tick("col_ld", 2, 0, 1, 0);
    load(7, 1'b0);
    tick("col_ign", 1, 0, 1, 0);
    stop = 1'b1;
    tick("col_stop", 1, 0, 0, 1);
    stop = 1'b0;
    tick("pend_ld", 7, 0, 1, 0);
    load_valid = 1'b0;
    stop = 1'b1;
    tick("pend_stop", 7, 0, 0, 1);
    tick("stop_idle", 7, 0, 0, 1);
    stop = 1'b0;

    load(0, 1'b0);
    tick("zero_ld", 0, 1, 0, 1);
    load_valid = 1'b0;
    tick("zero_end", 0, 0, 0, 1);

    load(5, 1'b0);
    tick("ar_ld", 5, 0, 1, 0);
    load_valid = 1'b0;
    enable = 1'b0;
    tick("ar_hold", 5, 0, 1, 0);
    reset = 1'b0;
    #2;
    chk("async.count", int'(count), 0);
    chk("async.busy", int'(busy), 0);
    chk("async.ready", int'(load_ready), 1);
    #2;
    tick("ar_held", 0, 0, 0, 1);
    reset  = 1'b1;
    enable = 1'b1;
    load(1, 1'b1);
    tick("p1_ld", 1, 0, 1, 0);
    load_valid = 1'b0;
    tick("p1", 1, 1, 1, 0);
    tick("p1", 1, 1, 1, 0);
    tick("p1", 1, 1, 1, 0);
    stop = 1'b1;
    tick("p1_stop", 1, 0, 0, 1);
    stop = 1'b0;

    load(255, 1'b0);
    tick("max_ld", 255, 0, 1, 0);
    load_valid = 1'b0;
    for (int k = 1; k < 255; k++) tick("max", 255 - k, 0, 1, 0);
    tick("max_tc", 0, 1, 0, 1);
    tick("max_end", 0, 0, 0, 1);
    tick("max_hold", 0, 0, 0, 1);

    chk("sb_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
